// File: rtl/n_term_route_bist_checker_pkg.sv
// Shared constants, state encoding and LFSR successor for the north-termination BIST checker.
package n_term_bist_pkg;

  localparam int unsigned TAP_W     = 52;
  localparam int unsigned CNT_W     = 20;
  localparam int unsigned BIT_IDX_W = 6;

  // Bit ranges of each northbound wire group inside the 52-bit tap word
  localparam int unsigned N1_LO  = 0;
  localparam int unsigned N1_HI  = 3;
  localparam int unsigned N2M_LO = 4;
  localparam int unsigned N2M_HI = 11;
  localparam int unsigned N2E_LO = 12;
  localparam int unsigned N2E_HI = 19;
  localparam int unsigned N4_LO  = 20;
  localparam int unsigned N4_HI  = 35;
  localparam int unsigned NN4_LO = 36;
  localparam int unsigned NN4_HI = 51;

  localparam int unsigned LFSR_TAP_A = 51;
  localparam int unsigned LFSR_TAP_B = 48;

  typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} bist_state_e;

  // Fibonacci LFSR, x^52 + x^49 + 1
  function automatic logic [TAP_W-1:0] lfsr52_next(input logic [TAP_W-1:0] s);
    return {s[TAP_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/n_term_route_bist_checker_if.sv
// Tap wires, run controls and results of the BIST checker.
// With N_TERM_BIST_WIRE_MASK_EN defined the interface also carries wire_mask.
interface n_term_route_bist_checker_if #(
  parameter int unsigned ERR_W = 16
);
  import n_term_bist_pkg::*;

  logic [N1_HI-N1_LO:0]   N1END;
  logic [N2M_HI-N2M_LO:0] N2MID;
  logic [N2E_HI-N2E_LO:0] N2END;
  logic [N4_HI-N4_LO:0]   N4END;
  logic [NN4_HI-NN4_LO:0] NN4END;
  logic                   start;
  logic                   clear;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [ERR_W-1:0]       err_count;
  logic [BIT_IDX_W-1:0]   first_bit;
  logic [CNT_W-1:0]       first_cycle;
`ifdef N_TERM_BIST_WIRE_MASK_EN
  logic [TAP_W-1:0]       wire_mask;

  modport master (output N1END, N2MID, N2END, N4END, NN4END, start, clear,
                  input  busy, done, pass, err_count, first_bit, first_cycle, wire_mask);
  modport slave  (input  N1END, N2MID, N2END, N4END, NN4END, start, clear,
                  output busy, done, pass, err_count, first_bit, first_cycle, wire_mask);
`else
  modport master (output N1END, N2MID, N2END, N4END, NN4END, start, clear,
                  input  busy, done, pass, err_count, first_bit, first_cycle);
  modport slave  (input  N1END, N2MID, N2END, N4END, NN4END, start, clear,
                  output busy, done, pass, err_count, first_bit, first_cycle);
`endif

endinterface

// File: rtl/n_term_route_bist_checker_first_fail.sv
// Lowest-set-bit encoder of the error vector plus the sticky latch of the first failing cycle/bit.
module n_term_bist_first_fail
  import n_term_bist_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 mis_i,
  input  logic [TAP_W-1:0]     diff_i,
  input  logic [CNT_W-1:0]     cycle_i,
  output logic [BIT_IDX_W-1:0] first_bit_o,
  output logic [CNT_W-1:0]     first_cycle_o
);

  logic                 seen_q, seen_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d, low_idx;
  logic [CNT_W-1:0]     cyc_q, cyc_d;

  // Scan high to low so the lowest set index wins; an all-zero vector encodes as 0
  always_comb begin
    low_idx = '0;
    for (int i = int'(TAP_W) - 1; i >= 0; i--) begin
      if (diff_i[i]) low_idx = BIT_IDX_W'(i);
    end
  end

  always_comb begin
    seen_d = seen_q;
    bit_d  = bit_q;
    cyc_d  = cyc_q;
    if (clr_i) begin
      seen_d = 1'b0;
      bit_d  = '0;
      cyc_d  = '0;
    end else if (en_i && mis_i && !seen_q) begin
      seen_d = 1'b1;
      bit_d  = low_idx;
      cyc_d  = cycle_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      bit_q  <= '0;
      cyc_q  <= '0;
    end else begin
      seen_q <= seen_d;
      bit_q  <= bit_d;
      cyc_q  <= cyc_d;
    end
  end

  assign first_bit_o   = bit_q;
  assign first_cycle_o = cyc_q;

endmodule

// File: rtl/n_term_route_bist_checker.sv
// Passive BIST checker on the 52 northbound termination wires: verifies each word is the LFSR successor of the last.
// Optional sticky per-wire error mask under N_TERM_BIST_WIRE_MASK_EN.
module n_term_route_bist_checker
  import n_term_bist_pkg::*;
#(
  parameter int unsigned CHECK_LEN = 1024,
  parameter int unsigned SYNC_LEN  = 4,
  parameter int unsigned ERR_W     = 16
) (
  input logic                          UserCLK,
  input logic                          RESETn,
  n_term_route_bist_checker_if.slave   bus
);

  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(CHECK_LEN - 1);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [TAP_W-1:0] tap, cap_q, prev_q, pred, diff;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             mismatch, res_clr, chk_en;

  always_comb begin
    tap                 = '0;
    tap[N1_HI:N1_LO]    = bus.N1END;
    tap[N2M_HI:N2M_LO]  = bus.N2MID;
    tap[N2E_HI:N2E_LO]  = bus.N2END;
    tap[N4_HI:N4_LO]    = bus.N4END;
    tap[NN4_HI:NN4_LO]  = bus.NN4END;
  end

  // A zero predecessor can never come from the generator, so it always fails
  assign pred     = lfsr52_next(prev_q);
  assign diff     = cap_q ^ pred;
  assign mismatch = (prev_q == '0) || (diff != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    res_clr = 1'b0;
    chk_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SYNC;
          cnt_d   = '0;
          err_d   = '0;
          res_clr = 1'b1;
        end
      end
      SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        chk_en = 1'b1;
        if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);
        if (cnt_q == CHECK_LAST) state_d = DONE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: begin
        // clear has priority over start
        if (bus.clear) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = '0;
          res_clr = 1'b1;
        end else if (bus.start) begin
          state_d = SYNC;
          cnt_d   = '0;
          err_d   = '0;
          res_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SYNC) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      cap_q   <= '0;
      prev_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      cap_q   <= tap;
      prev_q  <= cap_q;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  n_term_bist_first_fail u_first_fail (
    .clk           (UserCLK),
    .rst_n         (RESETn),
    .clr_i         (res_clr),
    .en_i          (chk_en),
    .mis_i         (mismatch),
    .diff_i        (diff),
    .cycle_i       (cnt_q),
    .first_bit_o   (bus.first_bit),
    .first_cycle_o (bus.first_cycle)
  );

`ifdef N_TERM_BIST_WIRE_MASK_EN
  logic [TAP_W-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (res_clr)     mask_d = '0;
    else if (chk_en) mask_d = mask_q | diff;
  end

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) mask_q <= '0;
    else         mask_q <= mask_d;
  end

  assign bus.wire_mask = mask_q;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;

endmodule

// File: doc/n_term_route_bist_checker.md
Name: n_term_route_bist_checker

Overview:
- Built-in self-test checker at the north termination edge. It sits directly upstream of the north termination switch matrix, on the same wires, as a passive tap on the 52 northbound wire ends (N1END, N2MID, N2END, N4END, NN4END) that the termination loops back south.
- The south-edge generator drives a 52-bit LFSR sequence up the columns. This block registers the arriving word and checks each word against the LFSR successor of the previous word. It then reports the mismatch count, the first failing wire and the first failing cycle.
- It is purely observational. It never drives fabric wires.

Parameters:
- CHECK_LEN, 1024: number of compared cycles per run, 1..2^20.
- SYNC_LEN, 4: capture cycles discarded before checking begins (pipeline fill), 1..255.
- ERR_W, 16: error counter width; the counter saturates at all-ones.

Ports:
- UserCLK, input, 1: fabric user clock.
- RESETn, input, 1: asynchronous active-low reset.
- N1END, input, 4: tap bits [3:0].
- N2MID, input, 8: tap bits [11:4].
- N2END, input, 8: tap bits [19:12].
- N4END, input, 16: tap bits [35:20].
- NN4END, input, 16: tap bits [51:36].
- start, input, 1: one-cycle pulse that begins a run; accepted only in IDLE or DONE.
- clear, input, 1: returns the block from DONE to IDLE and zeroes all results.
- busy, output, 1: high in SYNC and CHECK.
- done, output, 1: high in DONE.
- pass, output, 1: done and err_count==0.
- err_count, output, ERR_W: saturating mismatch count (cycles with at least one differing bit).
- first_bit, output, 6: lowest differing bit index on the first failing cycle.
- first_cycle, output, 20: CHECK cycle index (0-based) of the first failure.

Behaviour:
- Reset: state IDLE. All outputs are 0. Capture registers cap and prev are 0. The cycle counter is 0.
- Capture:
  - cap <= tap word every cycle, in every state. This is one cycle of input latency.
  - prev <= cap every cycle.
- LFSR successor (Fibonacci, polynomial x^52+x^49+1): nxt(s) = {s[50:0], s[51]^s[48]}.
- State transitions:
  - IDLE --start--> SYNC, with counter=0, err_count=0 and first_* = 0.
  - SYNC: counter increments each cycle. When counter==SYNC_LEN-1, go to CHECK with counter=0.
  - CHECK, each cycle:
    - mismatch = (cap != nxt(prev)).
    - On mismatch, err_count increments and saturates at all-ones.
    - On the first mismatch of the run, latch first_cycle=counter and first_bit = lowest set index of cap^nxt(prev).
    - When counter==CHECK_LEN-1, go to DONE after evaluating that cycle.
  - DONE: results are held. start begins a new run (SYNC) and clears the results. clear goes to IDLE and zeroes the results. If start and clear arrive in the same cycle, clear wins.
- start while busy is ignored. clear while busy is also ignored.
- A constant all-zero tap word counts as a mismatch, because nxt(0)=0 is never produced by the generator's nonzero seed and must fail. Mechanism: a cycle where prev==0 is always counted as a mismatch.
- RESETn asserted mid-run aborts the run immediately to the reset state. No partial results are retained.
- The counter width is 20 bits. No comparator exceeds CHECK_LEN-1.

Optional Feature:
- Macro N_TERM_BIST_WIRE_MASK_EN.
- When defined:
  - Adds output wire_mask, 52 bits.
  - Sticky OR of cap^nxt(prev) over all CHECK cycles (including cycles where prev==0).
  - Cleared on start, clear and reset.
- When undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Package n_term_bist_pkg holds:
  - TAP_W=52.
  - Tap bit-range constants per wire group.
  - The state enum (IDLE, SYNC, CHECK, DONE).
  - The LFSR tap positions (51, 48).
  - Function lfsr52_next.
- One sub-module, n_term_bist_first_fail, contains the 52-bit priority encoder plus the sticky first-fail latch.
- The FSM, counters and capture registers stay in the top module.

Test Plan:
1. Clean sequence: drive a valid LFSR stream (seed 52'h1) on the taps, pulse start.
   - busy is high for SYNC_LEN+CHECK_LEN cycles.
   - Then done=1, pass=1, err_count=0.
2. Single-bit fault: flip N4END[5] (tap bit 25) on CHECK cycle 100 only.
   - err_count=2, because the corrupted word also poisons the next prediction.
   - first_bit=25, first_cycle=100, pass=0.
3. Stuck wire: hold NN4END[15] (bit 51) at 0 during a valid stream.
   - err_count equals the number of cycles where the true bit 51 was 1, plus the poisoned successors.
   - first_bit=51.
   - With N_TERM_BIST_WIRE_MASK_EN defined, wire_mask[51]=1.
4. All-zero taps, pulse start.
   - err_count=min(CHECK_LEN, 2^ERR_W-1), first_cycle=0, first_bit=0.
   - With ERR_W=8, err_count=255 (saturated).
5. Controls in the wrong state:
   - start during CHECK is ignored.
   - In DONE, start and clear together leads to IDLE with all results 0.
   - clear during SYNC is ignored.
6. Reset mid-run: assert RESETn=0 at CHECK cycle 50.
   - All outputs are 0 in the same cycle (asynchronous).
   - After release, the state is IDLE.
   - A fresh run passes.
